// File: rtl/binary_divider_seq.sv
// binary_divider_seq: sequential restoring divider for unsigned mantissas.
// Computes Q = floor((A << FRAC) / B) and R = (A << FRAC) mod B, one quotient
// bit per clock, MSB first. A zero divisor skips the iteration and returns
// Q = all ones, R = A with dbz set.
// Optional feature: define BINDIV_STICKY_EN to add the `sticky` output
// (final remainder != 0), registered together with done.
module binary_divider_seq #(
    parameter int N    = 24,
    parameter int FRAC = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    output logic              busy,
    output logic              done,
    output logic              dbz,
    output logic [N+FRAC-1:0] Q,
    output logic [N-1:0]      R
`ifdef BINDIV_STICKY_EN
    ,
    output logic              sticky
`endif
);

    localparam int QW = N + FRAC;
    localparam int SW = $clog2(QW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;

    // Working registers of the iteration. The remainder itself always stays
    // below B, so it is held in N bits; the N+1-bit trial carries the extra
    // headroom needed for the shifted-in bit.
    logic [N-1:0]    a_sh_q, a_sh_d;    // dividend bits still to be consumed, MSB first
    logic [N-1:0]    b_q, b_d;          // latched divisor
    logic [N-1:0]    rem_q, rem_d;      // partial remainder
    logic [QW-1:0]   quo_q, quo_d;      // quotient shift register
    logic [SW-1:0]   step_q, step_d;    // index of the next quotient bit
    logic            zdiv_q, zdiv_d;    // current operation is a divide by zero

    // Result registers; they hold until the next completion or reset.
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [QW-1:0]   q_q, q_d;
    logic [N-1:0]    r_q, r_d;
`ifdef BINDIV_STICKY_EN
    logic            sticky_q, sticky_d;
`endif

    logic [N:0]      trial;
    logic            trial_ge;

    // One restoring step: bring down the next dividend bit and compare.
    // Once the N dividend bits are exhausted a_sh_q has shifted to zero, which
    // supplies the FRAC appended zero bits for free.
    always_comb begin
        trial    = {rem_q, a_sh_q[N-1]};
        trial_ge = (trial >= {1'b0, b_q});
    end

    // Next-state and datapath update for the control FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        step_d   = step_q;
        zdiv_d   = zdiv_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        q_d      = q_q;
        r_d      = r_q;
`ifdef BINDIV_STICKY_EN
        sticky_d = sticky_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d = A;
                    b_d    = B;
                    step_d = '0;
                    if (B == '0) begin
                        // No iteration: preload the divide-by-zero result.
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = A;
                        zdiv_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        quo_d   = '0;
                        rem_d   = '0;
                        zdiv_d  = 1'b0;
                    end
                end
            end

            S_RUN: begin
                a_sh_d = {a_sh_q[N-2:0], 1'b0};
                quo_d  = {quo_q[QW-2:0], trial_ge};
                // When trial_ge holds, trial - B < B, so the top bit is zero.
                rem_d  = trial_ge ? N'(trial - {1'b0, b_q}) : trial[N-1:0];
                step_d = step_q + SW'(1);
                if (step_q == SW'(QW - 1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Publish the result together with the single done pulse.
                state_d  = S_IDLE;
                done_d   = 1'b1;
                dbz_d    = zdiv_q;
                q_d      = quo_q;
                r_d      = rem_q;
`ifdef BINDIV_STICKY_EN
                sticky_d = (rem_q != '0);
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of the others, independent of statement order.
        if (!rst_n) begin
            // NOTE: every register, including the datapath, is cleared so that a
            // reset mid-operation leaves no stale quotient or remainder visible.
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            step_q   <= '0;
            zdiv_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
`ifdef BINDIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            step_q   <= step_d;
            zdiv_q   <= zdiv_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            q_q      <= q_d;
            r_q      <= r_d;
`ifdef BINDIV_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign dbz    = dbz_q;
    assign Q      = q_q;
    assign R      = r_q;
`ifdef BINDIV_STICKY_EN
    assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_binary_divider_seq.sv
// tb_binary_divider_seq: self-checking bench for binary_divider_seq (N=24, FRAC=24).
// A transaction-level model predicts, per clock edge, when each accepted
// operation completes and what it returns; a compare process checks all
// outputs against it every cycle. Directed tests pin the model with literals.
module tb_binary_divider_seq;

    localparam int N    = 24;
    localparam int FRAC = 24;
    localparam int QW   = N + FRAC;
    localparam int LAT  = QW + 1;     // accept edge to done cycle, normal operation
    localparam int PER  = QW + 2;     // issue period with start held high

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a, b;
    logic          busy, done, dbz;
    logic [QW-1:0] q;
    logic [N-1:0]  r;
`ifdef BINDIV_STICKY_EN
    logic          sticky;
`endif

    int checks   = 0;
    int failures = 0;

    binary_divider_seq #(.N(N), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .Q     (q),
        .R     (r)
`ifdef BINDIV_STICKY_EN
        ,
        .sticky(sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An accepted operation at edge t shows done after edge t+LAT (t+1 for a
    // zero divisor), keeps busy after edges t..t+QW-1, and the block accepts
    // again from edge t+PER (t+2 for a zero divisor).
    longint        cyc = 0;
    bit            mvalid = 1'b0;
    longint        done_at, busy_lo, busy_hi, free_at;
    logic [QW-1:0] pend_q, vis_q;
    logic [N-1:0]  pend_r, vis_r;
    logic          pend_dbz, vis_dbz;

    always @(posedge clk) begin
        logic [QW-1:0] num;
        cyc++;
        if (!rst_n) begin
            mvalid  = 1'b1;
            done_at = -1;
            busy_lo = 0;
            busy_hi = -1;
            free_at = cyc + 1;
            vis_q   = '0;
            vis_r   = '0;
            vis_dbz = 1'b0;
        end else if (mvalid) begin
            if (cyc == done_at) begin
                vis_q   = pend_q;
                vis_r   = pend_r;
                vis_dbz = pend_dbz;
            end
            if (start && cyc >= free_at) begin
                if (b == '0) begin
                    pend_q   = '1;
                    pend_r   = a;
                    pend_dbz = 1'b1;
                    done_at  = cyc + 1;
                    busy_lo  = 0;
                    busy_hi  = -1;
                    free_at  = cyc + 2;
                end else begin
                    num      = {a, {FRAC{1'b0}}};
                    pend_q   = num / {{FRAC{1'b0}}, b};
                    pend_r   = N'(num % {{FRAC{1'b0}}, b});
                    pend_dbz = 1'b0;
                    done_at  = cyc + LAT;
                    busy_lo  = cyc;
                    busy_hi  = cyc + QW - 1;
                    free_at  = cyc + PER;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            check("done", done, (cyc == done_at));
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            check("Q", q, vis_q);
            check("R", r, vis_r);
            check("dbz", dbz, vis_dbz);
`ifdef BINDIV_STICKY_EN
            check("sticky", sticky, (vis_r != '0));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Pulse start for one cycle and return the number of edges from the
    // accept edge to the first cycle with done high (-1 on timeout).
    task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            lat;
        int            t_done [3];
        int            seen;
        int            pulses;
        logic [N-1:0]  ra, rb;
        logic [79:0]   recon;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_Q", q, '0);
        rst_n = 1'b1;

        // 1. 1.5 / 1.0
        do_op(24'hC00000, 24'h800000, lat);
        check("t1_latency", lat, 49);
        check("t1_Q", q, 48'h000001800000);
        check("t1_R", r, 24'h000000);
        check("t1_dbz", dbz, 1'b0);

        // 2. 1 / 3 leaves a remainder
        do_op(24'h000001, 24'h000003, lat);
        check("t2_latency", lat, 49);
        check("t2_Q", q, 48'h000000555555);
        check("t2_R", r, 24'h000001);
`ifdef BINDIV_STICKY_EN
        check("t2_sticky", sticky, 1'b1);
`endif

        // 3. divide by zero: no busy, done right after the DONE state
        do_op(24'h800000, 24'h000000, lat);
        check("t3_latency", lat, 1);
        check("t3_Q", q, 48'hFFFFFFFFFFFF);
        check("t3_R", r, 24'h800000);
        check("t3_dbz", dbz, 1'b1);

        // Boundary operands
        do_op(24'h000000, 24'h123456, lat);
        check("a0_latency", lat, 49);
        check("a0_Q", q, 48'h0);
        check("a0_R", r, 24'h0);
        do_op(24'hFFFFFF, 24'h000001, lat);
        check("bmin_Q", q, 48'hFFFFFF000000);
        check("bmin_R", r, 24'h0);
        do_op(24'h000001, 24'hFFFFFF, lat);
        check("bmax_Q", q, 48'h000000000001);
        check("bmax_R", r, 24'h000001);

        // Inputs changed, and start re-asserted, while busy are ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 24'h800000;
        b     = 24'h800000;
        @(negedge clk);
        start = 1'b0;
        a     = 24'h000001;
        b     = 24'h000003;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        check("inflight_done_seen", (lat > 0), 1'b1);
        check("inflight_Q", q, 48'h000001000000);
        check("inflight_R", r, 24'h0);

        // 4. start held high: a done pulse every 50 cycles
        @(negedge clk);
        start = 1'b1;
        a     = 24'h800000;
        b     = 24'h800000;
        seen  = 0;
        for (int n = 0; n < 400 && seen < 3; n++) begin
            @(negedge clk);
            if (done) begin
                t_done[seen] = n;
                seen++;
                check("held_Q", q, 48'h000001000000);
                check("held_R", r, 24'h0);
            end
        end
        start = 1'b0;
        check("held_pulses", seen, 3);
        if (seen == 3) begin
            check("held_period1", t_done[1] - t_done[0], 50);
            check("held_period2", t_done[2] - t_done[1], 50);
        end
        repeat (60) @(negedge clk);

        // 5. reset at step 20 of a RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        a     = 24'hC00000;
        b     = 24'h800000;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_Q", q, '0);
        check("abort_R", r, '0);
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_op(24'hC00000, 24'h800000, lat);
        check("after_abort_latency", lat, 49);
        check("after_abort_Q", q, 48'h000001800000);

        // 6. random operands; the model checks every cycle, plus the
        //    arithmetic identities checked directly here
        for (int i = 0; i < 300; i++) begin
            ra = N'($urandom);
            rb = (i % 2 == 0) ? N'($urandom) : N'($urandom_range(1, 255));
            if (rb == '0) rb = 24'h000001;
            do_op(ra, rb, lat);
            check("rnd_latency", lat, 49);
            recon = 80'(q) * 80'(rb) + 80'(r);
            check("rnd_QB_plus_R", recon, 80'({ra, {FRAC{1'b0}}}));
            check("rnd_R_lt_B", (r < rb), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
